// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed common-anode seven-segment scan controller.
// Scans D digits from slot D-1 down to 0, one slot every 2^CLK_DIV_LOG2 cycles.
// Inputs are captured into shadow registers only at the frame boundary, so a
// frame is never torn. Brightness is a PWM duty taken from the top prescaler bits.
// Optional feature: define DISP_LZ_BLANK_EN for leading-zero suppression.

module disp_scan_ctrl #(
    parameter int D            = 4,
    parameter int CLK_DIV_LOG2 = 10,
    parameter int BRIGHT_W     = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [D-1:0][3:0]   digits,
    input  logic [D-1:0]        dp,
    input  logic [D-1:0]        blank,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [D-1:0]        an,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic                frame_start
);

    // Slot address needs at least one bit so a single-digit build still elaborates;
    // with D = 1 it simply stays at 0.
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam logic [AW-1:0] LAST_SLOT = AW'(D - 1);

    logic [CLK_DIV_LOG2-1:0] pre;
    logic [AW-1:0]           addr;
    logic                    slot_end;
    logic                    frame_end;
    logic                    frame_end_q;

    logic [D-1:0][3:0]       digits_sh;
    logic [D-1:0]            dp_sh;
    logic [D-1:0]            blank_sh;
    logic [BRIGHT_W-1:0]     bright_sh;

    logic [D-1:0]            lz_sh;
    logic                    duty_on;
    logic                    lit;
    logic [D-1:0]            slot_sel;
    logic [D-1:0]            an_next;
    logic [6:0]              seg_next;
    logic                    dp_n_next;

    // Active-low hex font, segment a on bit 0 through g on bit 6.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    assign slot_end  = &pre;
    assign frame_end = slot_end && (addr == '0);

    // Prescaler free-runs; the slot address steps down at the end of each slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre  <= '0;
            addr <= LAST_SLOT;
        end else begin
            pre <= pre + 1'b1;
            if (slot_end) begin
                if (addr == '0) begin
                    addr <= LAST_SLOT;
                end else begin
                    addr <= addr - AW'(1);
                end
            end
        end
    end

    // Shadow copy of the inputs, refreshed only on the frame boundary edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_sh <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            bright_sh <= '0;
        end else if (frame_end) begin
            digits_sh <= digits;
            dp_sh     <= dp;
            blank_sh  <= blank;
            bright_sh <= brightness;
        end
    end

    // Remembers that a boundary just happened so frame_start lines up with slot D-1 output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= frame_end;
        end
    end

`ifdef DISP_LZ_BLANK_EN
    // A digit above slot 0 is suppressed when it and every higher digit is zero with no dp.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_sh    = '0;
        for (int i = D - 1; i >= 1; i--) begin
            zero_run = zero_run && (digits_sh[i] == 4'h0) && !dp_sh[i];
            lz_sh[i] = zero_run;
        end
    end
`else
    assign lz_sh = '0;
`endif

    // Decide whether the addressed slot is lit and build the next output pattern.
    always_comb begin
        duty_on       = pre[CLK_DIV_LOG2-1 -: BRIGHT_W] < bright_sh;
        lit           = ((&bright_sh) || duty_on) && !blank_sh[addr] && !lz_sh[addr];
        slot_sel      = '0;
        slot_sel[addr] = 1'b1;
        an_next       = lit ? ~slot_sel : '1;
        seg_next      = hex_font(digits_sh[addr]);
        dp_n_next     = ~dp_sh[addr];
    end

    // Output register: pins reflect the scan state of the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= seg_next;
            dp_n        <= dp_n_next;
            frame_start <= frame_end_q;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl (D=4, CLK_DIV_LOG2=4, BRIGHT_W=2).
// The reference model works from elapsed cycles since reset: frame, slot and PWM
// phase come from plain division, shadows are snapshots taken at frame ends.

module tb_disp_scan_ctrl;

    localparam int D     = 4;
    localparam int CDL   = 4;
    localparam int BW    = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = D * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       frame_start;
    } out_t;

    localparam out_t RST_OUT = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, frame_start: 1'b0};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [D-1:0][3:0] digits;
    logic [D-1:0]      dp;
    logic [D-1:0]      blank;
    logic [BW-1:0]     brightness;
    logic [D-1:0]      an;
    logic [6:0]        seg;
    logic              dp_n;
    logic              frame_start;

    int checks = 0;
    int errors = 0;

    out_t exp_q[$];

    int                cyc;
    logic [D-1:0][3:0] sh_digits;
    logic [D-1:0]      sh_dp;
    logic [D-1:0]      sh_blank;
    logic [BW-1:0]     sh_bright;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    disp_scan_ctrl #(.D(D), .CLK_DIV_LOG2(CDL), .BRIGHT_W(BW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected pins for the cycle after elapsed-cycle index c.
    function automatic out_t model_out(input int c);
        out_t r;
        int   w;
        int   slot;
        int   phase;
        bit   lit;
        bit   lz;
        w     = c % FRAME;
        slot  = (D - 1) - (w / SLOT);
        phase = (w % SLOT) / (SLOT >> BW);
        lit   = (sh_bright == 2'd3) || (phase < int'(sh_bright));
        if (sh_blank[slot]) lit = 1'b0;
        lz = 1'b0;
`ifdef DISP_LZ_BLANK_EN
        if (slot >= 1) begin
            lz = 1'b1;
            for (int j = slot; j < D; j++) begin
                if (sh_digits[j] != 4'h0 || sh_dp[j]) lz = 1'b0;
            end
        end
`endif
        if (lz) lit = 1'b0;
        r.an          = lit ? ~(4'b0001 << slot) : 4'hF;
        r.seg         = font[sh_digits[slot]];
        r.dp_n        = ~sh_dp[slot];
        r.frame_start = (w == 0) && (c >= FRAME);
        return r;
    endfunction

    // Reference model: predicts each cycle's outputs and snapshots inputs at frame ends.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc       = 0;
            sh_digits = '0;
            sh_dp     = '0;
            sh_blank  = '0;
            sh_bright = '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out(cyc));
            if (cyc % FRAME == FRAME - 1) begin
                sh_digits = digits;
                sh_dp     = dp;
                sh_blank  = blank;
                sh_bright = brightness;
            end
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input out_t e);
        out_t act;
        act = '{an: an, seg: seg, dp_n: dp_n, frame_start: frame_start};
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got an=%h seg=%h dp_n=%b fs=%b expected an=%h seg=%h dp_n=%b fs=%b",
                     name, $time, act.an, act.seg, act.dp_n, act.frame_start,
                     e.an, e.seg, e.dp_n, e.frame_start);
        end
    endtask

    // Monitor: every cycle pops the prediction and compares on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("reset_hold", RST_OUT);
        end else if (exp_q.size() > 0) begin
            checkOutput("scan", exp_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic [15:0] dg, input logic [3:0] d,
                                 input logic [3:0] b, input logic [1:0] br);
        digits     = dg;
        dp         = d;
        blank      = b;
        brightness = br;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitPhase(input int target);
        for (int i = 0; i < FRAME && (cyc % FRAME) != target; i++) waitCycles(1);
    endtask

    task automatic finishRun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        finishRun();
    end

    // Stimulus: directed test-plan scenarios, then randomized input traffic.
    initial begin
        logic [15:0] rd;
        logic [3:0]  rdp;
        logic [3:0]  rbl;
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 2'd3);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        waitCycles(1);

        $display("[TB] dark first frame, then 1234 at full brightness");
        waitCycles(2 * FRAME + 10);

        $display("[TB] mid-frame change to ABCD");
        waitPhase(20);
        applyStimulus(16'hABCD, 4'b0000, 4'b0000, 2'd3);
        waitCycles(2 * FRAME);

        $display("[TB] brightness 1 then 0");
        applyStimulus(16'hABCD, 4'b0000, 4'b0000, 2'd1);
        waitCycles(2 * FRAME);
        applyStimulus(16'hABCD, 4'b0000, 4'b0000, 2'd0);
        waitCycles(2 * FRAME);

        $display("[TB] blank slot 2, dp on slot 0");
        applyStimulus(16'h1234, 4'b0001, 4'b0100, 2'd3);
        waitCycles(2 * FRAME);

        $display("[TB] leading-zero patterns");
        applyStimulus(16'h0050, 4'b0000, 4'b0000, 2'd3);
        waitCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'b0000, 4'b0000, 2'd3);
        waitCycles(2 * FRAME);
        applyStimulus(16'h0000, 4'b0100, 4'b0000, 2'd3);
        waitCycles(2 * FRAME);

        $display("[TB] change coincident with frame boundary edge");
        waitPhase(FRAME - 1);
        applyStimulus(16'h9E7F, 4'b1010, 4'b0000, 2'd2);
        waitCycles(FRAME + 5);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1600; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                for (int k = 0; k < D; k++) begin
                    rd[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                rdp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                rbl = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                applyStimulus(rd, rdp, rbl, 2'($urandom_range(0, 3)));
            end
            waitCycles(1);
        end

        $display("[TB] asynchronous reset in the middle of slot 1");
        applyStimulus(16'h8888, 4'b1111, 4'b0000, 2'd3);
        waitCycles(FRAME);
        waitPhase(40);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset", RST_OUT);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        waitCycles(2 * FRAME + 8);

        finishRun();
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Parametrised multiplexed seven-segment scan controller; successor to the fixed four-digit display driver, which decremented its digit select on every clock. Drives D common-anode digits with a programmable scan prescaler, per-digit decimal point and blank, PWM brightness, and frame-synchronous (tear-free) input capture. Sits between the lab datapath (hex/BCD nibbles) and the board's anode/segment pins.

## Interface
- D, 4, number of digits, 1..8
- CLK_DIV_LOG2, 10, log2 of clock cycles per digit slot; must be ≥ BRIGHT_W
- BRIGHT_W, 3, brightness control width, 1..CLK_DIV_LOG2

- clk  in  1  system clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- digits  in  [D-1:0][3:0]  nibble per digit, index 0 = rightmost
- dp  in  D  decimal point request per digit, active-high
- blank  in  D  force digit dark, active-high
- brightness  in  BRIGHT_W  duty: 0 = off, all-ones = 100 %
- an  out  D  anode enables, active-low, one-hot-low or all-ones
- seg  out  7  segments a..g on bits 0..6, active-low
- dp_n  out  1  decimal point segment, active-low
- frame_start  out  1  one-cycle pulse in the first cycle of each frame

## Operation
- Prescaler pre: CLK_DIV_LOG2-bit counter, increments every cycle, wraps to 0.
- Slot counter addr: $clog2(D) bits (constant 0 when D = 1); scan order D-1, D-2, …, 0, then back to D-1. addr steps when pre is all-ones.
- Frame = D × 2^CLK_DIV_LOG2 cycles. Frame boundary = pre all-ones and addr == 0.
- Shadow registers (digits, dp, blank, brightness) load from the inputs only at the frame boundary edge. Input changes mid-frame never appear on the outputs until the next frame.
- Slot lit iff bright_sh == all-ones, or pre[CLK_DIV_LOG2-1 -: BRIGHT_W] < bright_sh; and blank_sh[addr] == 0 (and not LZ-suppressed, see Configuration).
- When lit: an = ~(1 << addr); otherwise an = all-ones. seg and dp_n always carry the addressed digit's pattern, even while dark.
- Font: active-low hex, 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- dp_n = ~dp_sh[addr].

## Timing
- Reset (asynchronous assert, synchronous-release by the system): pre = 0, addr = D-1, all shadows = 0, an = all-ones, seg = 7'h7F, dp_n = 1, frame_start = 0.
- Display is dark for the first frame after reset (bright_sh = 0); inputs first sampled at the end of that frame.
- an, seg, dp_n, frame_start are registered: they reflect (addr, pre, shadows) of the preceding cycle; one-cycle latency.
- frame_start high exactly one cycle per frame, in the cycle outputs first show slot D-1 of the new shadow data.
- Reset mid-frame: all outputs go to reset values immediately; scan restarts at slot D-1, pre = 0.
- Input change coincident with the boundary edge is captured (sampled on that edge).

## Configuration
- DISP_LZ_BLANK_EN defined: leading-zero suppression on the shadow data. Digit i (i ≥ 1) is dark if digits_sh[j] == 0 and dp_sh[j] == 0 for all j ≥ i. Digit 0 is never suppressed. Suppressed digits also suppress their dp.
- Not defined: every non-blanked digit is displayed, zeros included; no suppression logic is synthesised.

## Test plan
(D=4, CLK_DIV_LOG2=4, BRIGHT_W=2; frame = 64 cycles)
- Reset, digits=16'h1234, brightness=3 → frame 0 all dark (an=4'hF); frame_start after 64 cycles; frame 1 shows an=4'b0111 seg=7'h79 for 16 cycles, then 4'b1011/7'h24, 4'b1101/7'h30, 4'b1110/7'h19.
- brightness=1 → each slot lit for cycles with pre[3:2]==0 only (4 of 16); brightness=0 → an=4'hF all frame.
- Change digits from 16'h1234 to 16'hABCD at mid-frame → current frame still shows 1,2,3,4; next frame shows 7'h08,7'h03,7'h46,7'h21.
- blank=4'b0100, dp=4'b0001 → slot 2 an stays 4'hF; slot 0 dp_n=0, others dp_n=1.
- With DISP_LZ_BLANK_EN: digits=16'h0050 → slots 3,2 dark, slot 1 shows 7'h12, slot 0 7'h40; digits=16'h0000 → only slot 0 lit; dp=4'b0100 → slot 2 lit (7'h40, dp_n=0). Without macro all four lit.
- Assert reset_n=0 mid-slot 1 → outputs an=4'hF, seg=7'h7F, dp_n=1 same cycle (asynchronous); after release scan restarts at slot 3, display dark one frame.
